// File: rtl/piece_engine.sv
// rtl/piece_engine.sv - active falling-piece engine: spawn, moves, rotation, collision check and lock
module piece_engine #(
    parameter int COLS    = 10,
    parameter int ROWS    = 20,
    parameter int XW      = 4,
    parameter int YW      = 5,
    parameter int SPAWN_X = 3
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    input  logic               left_final,
    input  logic               right_final,
    input  logic               rot_final,
    input  logic               tick_gravity,
    input  logic [2:0]         spawn_shape,
    input  logic               clear_done,
    output logic [XW-1:0]      board_rx,
    output logic [YW-1:0]      board_ry,
    input  logic               board_rdata,
    output logic               board_we,
    output logic [XW-1:0]      board_wx,
    output logic [YW-1:0]      board_wy,
    output logic               board_wdata,
    output logic signed [XW:0] piece_x,
    output logic signed [YW:0] piece_y,
    output logic [1:0]         rot,
    output logic [2:0]         shape_id,
    output logic               lock_done,
    output logic               game_over,
    output logic               busy
);

    localparam int XS = XW + 2;
    localparam int YS = YW + 2;
    localparam logic signed [XS-1:0] COLS_S    = XS'(COLS);
    localparam logic signed [YS-1:0] ROWS_S    = YS'(ROWS);
    localparam logic signed [XW:0]   SPAWN_X_S = (XW+1)'(SPAWN_X);

    typedef enum logic [2:0] {
        S_IDLE, S_SPAWN, S_FALL, S_CHECK, S_LOCK, S_WAIT_CLR, S_OVER
    } state_t;

    typedef enum logic [1:0] {K_SPAWN, K_SHIFT, K_ROT, K_GRAV} kind_t;

    // Returns {dx,dy} of cell i; each clockwise step maps (dx,dy) -> (3-dy,dx).
    function automatic logic [3:0] cell_off(input logic [2:0] shape, input logic [1:0] r,
                                            input logic [1:0] i);
        logic [15:0] tab;
        logic [1:0]  dx;
        logic [1:0]  dy;
        logic [1:0]  n;
        case (shape)
            3'd1:    tab = 16'h9584;
            3'd2:    tab = 16'h9514;
            3'd3:    tab = 16'h5184;
            3'd4:    tab = 16'h9540;
            3'd5:    tab = 16'h9510;
            3'd6:    tab = 16'h9518;
            default: tab = 16'hD951;
        endcase
        {dx, dy} = tab[{i, 2'b00} +: 4];
        n = (shape == 3'd1) ? 2'd0 : r;
        for (int k = 0; k < 3; k++) begin
            if (k < int'(n)) {dx, dy} = {~dy, dx};
        end
        return {dx, dy};
    endfunction

    state_t            state_q, state_d;
    kind_t             kind_q, kind_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              coll_q, coll_d;
    logic              prev_oob_q, prev_oob_d;
    logic [1:0]        dx_q, dx_d;
    logic              dy_q, dy_d;
    logic              drot_q, drot_d;
    logic signed [XW:0] piece_x_q, piece_x_d;
    logic signed [YW:0] piece_y_q, piece_y_d;
    logic [1:0]        rot_q, rot_d;
    logic [2:0]        shape_q, shape_d;
    logic              lock_done_q, lock_done_d;

    logic [1:0]        use_dx;
    logic              use_dy;
    logic [1:0]        use_rot;
    logic [3:0]        off;
    logic signed [XS-1:0] tx;
    logic signed [YS-1:0] ty;
    logic              oob;
    logic              hit;
    logic              coll_now;

    // Target cell of the current counter: CHECK applies the pending delta, LOCK uses the piece as is.
    always_comb begin
        use_dx  = 2'b00;
        use_dy  = 1'b0;
        use_rot = rot_q;
        if (state_q == S_CHECK) begin
            use_dx  = dx_q;
            use_dy  = dy_q;
            use_rot = rot_q + {1'b0, drot_q};
        end
        off = cell_off(shape_q, use_rot, cnt_q[1:0]);
        tx  = {piece_x_q[XW], piece_x_q} + {{XW{use_dx[1]}}, use_dx} + {{XW{1'b0}}, off[3:2]};
        ty  = {piece_y_q[YW], piece_y_q} + {{(YW+1){1'b0}}, use_dy} + {{YW{1'b0}}, off[1:0]};
        oob = tx[XS-1] || (tx >= COLS_S) || ty[YS-1] || (ty >= ROWS_S);
    end

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        cnt_d       = cnt_q;
        coll_d      = coll_q;
        prev_oob_d  = prev_oob_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        drot_d      = drot_q;
        piece_x_d   = piece_x_q;
        piece_y_d   = piece_y_q;
        rot_d       = rot_q;
        shape_d     = shape_q;
        lock_done_d = 1'b0;
        // rdata belongs to the previous cycle's address; out-of-range cells never read the board.
        hit         = (cnt_q != 3'd0) && !prev_oob_q && board_rdata;
        coll_now    = coll_q | hit | (!cnt_q[2] & oob);
        case (state_q)
            S_IDLE: state_d = S_SPAWN;
            S_SPAWN: begin
                shape_d    = (spawn_shape == 3'd7) ? 3'd0 : spawn_shape;
                rot_d      = 2'd0;
                piece_x_d  = SPAWN_X_S;
                piece_y_d  = '0;
                dx_d       = 2'b00;
                dy_d       = 1'b0;
                drot_d     = 1'b0;
                kind_d     = K_SPAWN;
                cnt_d      = 3'd0;
                coll_d     = 1'b0;
                prev_oob_d = 1'b1;
                state_d    = S_CHECK;
            end
            S_FALL: begin
                cnt_d      = 3'd0;
                coll_d     = 1'b0;
                prev_oob_d = 1'b1;
                dx_d       = 2'b00;
                dy_d       = 1'b0;
                drot_d     = 1'b0;
                if (left_final) begin
                    dx_d = 2'b11; kind_d = K_SHIFT; state_d = S_CHECK;
                end else if (right_final) begin
                    dx_d = 2'b01; kind_d = K_SHIFT; state_d = S_CHECK;
                end else if (rot_final) begin
                    drot_d = 1'b1; kind_d = K_ROT; state_d = S_CHECK;
                end else if (tick_gravity) begin
                    dy_d = 1'b1; kind_d = K_GRAV; state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                prev_oob_d = oob;
                coll_d     = coll_now;
                cnt_d      = cnt_q + 3'd1;
                if (cnt_q[2]) begin
                    if (!coll_now) begin
                        piece_x_d = piece_x_q + {{(XW-1){dx_q[1]}}, dx_q};
                        piece_y_d = piece_y_q + {{YW{1'b0}}, dy_q};
                        rot_d     = rot_q + {1'b0, drot_q};
                        state_d   = S_FALL;
                    end else begin
                        case (kind_q)
                            K_GRAV:  begin state_d = S_LOCK; cnt_d = 3'd0; end
                            K_SPAWN: state_d = S_OVER;
                            default: state_d = S_FALL;
                        endcase
                    end
                end
            end
            S_LOCK: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q[1:0] == 2'd3) begin
                    lock_done_d = 1'b1;
                    state_d     = S_WAIT_CLR;
                end
            end
            S_WAIT_CLR: if (clear_done) state_d = S_SPAWN;
            S_OVER:  state_d = S_OVER;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            kind_q      <= K_SPAWN;
            cnt_q       <= 3'd0;
            coll_q      <= 1'b0;
            prev_oob_q  <= 1'b1;
            dx_q        <= 2'b00;
            dy_q        <= 1'b0;
            drot_q      <= 1'b0;
            piece_x_q   <= '0;
            piece_y_q   <= '0;
            rot_q       <= 2'd0;
            shape_q     <= 3'd0;
            lock_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            cnt_q       <= cnt_d;
            coll_q      <= coll_d;
            prev_oob_q  <= prev_oob_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            drot_q      <= drot_d;
            piece_x_q   <= piece_x_d;
            piece_y_q   <= piece_y_d;
            rot_q       <= rot_d;
            shape_q     <= shape_d;
            lock_done_q <= lock_done_d;
        end
    end

    always_comb begin
        board_rx    = '0;
        board_ry    = '0;
        board_we    = 1'b0;
        board_wx    = '0;
        board_wy    = '0;
        board_wdata = 1'b0;
        if (state_q == S_CHECK && !cnt_q[2]) begin
            board_rx = tx[XW-1:0];
            board_ry = ty[YW-1:0];
        end
        if (state_q == S_LOCK) begin
            board_we    = 1'b1;
            board_wdata = 1'b1;
            board_wx    = tx[XW-1:0];
            board_wy    = ty[YW-1:0];
        end
    end

    assign piece_x   = piece_x_q;
    assign piece_y   = piece_y_q;
    assign rot       = rot_q;
    assign shape_id  = shape_q;
    assign lock_done = lock_done_q;
    assign game_over = (state_q == S_OVER);
    assign busy      = (state_q != S_FALL);

endmodule

// File: tb/tb_piece_engine.sv
// tb/tb_piece_engine.sv - self-checking bench for piece_engine with a board model and write scoreboard
module tb_piece_engine;
    localparam int XW = 4;
    localparam int YW = 5;

    logic              CLOCK_50 = 1'b0;
    logic              resetn = 1'b0;
    logic              left_final = 1'b0, right_final = 1'b0, rot_final = 1'b0;
    logic              tick_gravity = 1'b0, clear_done = 1'b0;
    logic [2:0]        spawn_shape = 3'd0;
    logic [XW-1:0]     board_rx, board_wx;
    logic [YW-1:0]     board_ry, board_wy;
    logic              board_rdata = 1'b0;
    logic              board_we, board_wdata;
    logic signed [XW:0] piece_x;
    logic signed [YW:0] piece_y;
    logic [1:0]        rot;
    logic [2:0]        shape_id;
    logic              lock_done, game_over, busy;

    typedef struct packed { logic [XW-1:0] x; logic [YW-1:0] y; logic d; } wr_t;
    wr_t exp_q[$];
    wr_t obs_q[$];
    int  n_checks = 0, n_fail = 0, cyc = 0, last_we_cyc = -100, obs_rd = 0;
    logic board [0:31][0:15];

    piece_engine dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn),
        .left_final(left_final), .right_final(right_final), .rot_final(rot_final),
        .tick_gravity(tick_gravity), .spawn_shape(spawn_shape), .clear_done(clear_done),
        .board_rx(board_rx), .board_ry(board_ry), .board_rdata(board_rdata),
        .board_we(board_we), .board_wx(board_wx), .board_wy(board_wy), .board_wdata(board_wdata),
        .piece_x(piece_x), .piece_y(piece_y), .rot(rot), .shape_id(shape_id),
        .lock_done(lock_done), .game_over(game_over), .busy(busy)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;
    always @(posedge CLOCK_50) board_rdata <= board[board_ry][board_rx];

    always @(negedge CLOCK_50) begin
        if (board_we === 1'b1) begin
            obs_q.push_back('{x: board_wx, y: board_wy, d: board_wdata});
            last_we_cyc <= cyc;
        end
    end

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic clear_board();
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 16; x++) board[y][x] = 1'b0;
    endtask

    task automatic wait_fall(output int n);
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic do_reset(input logic [2:0] shape, output int n);
        resetn = 1'b0;
        step();
        step();
        spawn_shape = shape;
        resetn = 1'b1;
        wait_fall(n);
    endtask

    task automatic request(input int which, output int n);
        left_final   = (which == 0);
        right_final  = (which == 1);
        rot_final    = (which == 2);
        tick_gravity = (which == 3);
        step();
        left_final = 1'b0; right_final = 1'b0; rot_final = 1'b0; tick_gravity = 1'b0;
        wait_fall(n);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        step();
        step();
        n_checks++;
        if (piece_x !== 5'sd0 || piece_y !== 6'sd0 || rot !== 2'd0 || shape_id !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_piece: got x=%0d y=%0d rot=%0d shape=%0d, want all 0", piece_x, piece_y, rot, shape_id);
        end
        n_checks++;
        if (board_we !== 1'b0 || board_wdata !== 1'b0 || board_wx !== 4'd0 || board_wy !== 5'd0 ||
            board_rx !== 4'd0 || board_ry !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_board_port: got we=%b wd=%b wx=%0d wy=%0d rx=%0d ry=%0d, want 0", board_we, board_wdata, board_wx, board_wy, board_rx, board_ry);
        end
        n_checks++;
        if (lock_done !== 1'b0 || game_over !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_flags: got lock_done=%b game_over=%b busy=%b, want 0 0 1", lock_done, game_over, busy);
        end
    endtask

    task automatic test_spawn();
        int n;
        do_reset(3'd2, n);
        n_checks++;
        if (n !== 7) begin n_fail++; $display("FAIL spawn_latency: got %0d cycles, want 7", n); end
        n_checks++;
        if (piece_x !== 5'sd3 || piece_y !== 6'sd0 || rot !== 2'd0 || shape_id !== 3'd2) begin
            n_fail++;
            $display("FAIL spawn_state: got x=%0d y=%0d rot=%0d shape=%0d, want 3 0 0 2", piece_x, piece_y, rot, shape_id);
        end
        n_checks++;
        if (game_over !== 1'b0) begin n_fail++; $display("FAIL spawn_game_over: got %b, want 0", game_over); end
    endtask

    task automatic test_move();
        int n;
        for (int i = 0; i < 3; i++) request(0, n);
        n_checks++;
        if (piece_x !== 5'sd0) begin n_fail++; $display("FAIL move_left3: got x=%0d, want 0", piece_x); end
        request(0, n);
        n_checks++;
        if (piece_x !== 5'sd0 || n !== 5) begin
            n_fail++;
            $display("FAIL left_wall: got x=%0d check_cycles=%0d, want x=0 cycles=5", piece_x, n);
        end
        clear_done = 1'b1;
        step();
        clear_done = 1'b0;
        step();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_done_in_fall: got busy=%b, want 0", busy); end
        request(1, n);
        n_checks++;
        if (piece_x !== 5'sd1) begin n_fail++; $display("FAIL move_right: got x=%0d, want 1", piece_x); end
    endtask

    task automatic test_priority();
        int n;
        left_final = 1'b1; tick_gravity = 1'b1;
        step();
        left_final = 1'b0; tick_gravity = 1'b0;
        wait_fall(n);
        n_checks++;
        if (piece_x !== 5'sd0 || piece_y !== 6'sd0) begin
            n_fail++;
            $display("FAIL left_over_gravity: got x=%0d y=%0d, want 0 0", piece_x, piece_y);
        end
        right_final = 1'b1; rot_final = 1'b1;
        step();
        right_final = 1'b0; rot_final = 1'b0;
        wait_fall(n);
        n_checks++;
        if (piece_x !== 5'sd1 || rot !== 2'd0) begin
            n_fail++;
            $display("FAIL right_over_rot: got x=%0d rot=%0d, want 1 0", piece_x, rot);
        end
        right_final = 1'b1;
        step();
        right_final = 1'b0;
        tick_gravity = 1'b1;
        step();
        tick_gravity = 1'b0;
        wait_fall(n);
        n_checks++;
        if (piece_x !== 5'sd2 || piece_y !== 6'sd0) begin
            n_fail++;
            $display("FAIL gravity_during_check: got x=%0d y=%0d, want 2 0", piece_x, piece_y);
        end
        request(3, n);
        n_checks++;
        if (piece_y !== 6'sd1) begin n_fail++; $display("FAIL gravity_step: got y=%0d, want 1", piece_y); end
    endtask

    task automatic test_rotate();
        int n;
        do_reset(3'd0, n);
        board[3][5] = 1'b1;
        request(2, n);
        n_checks++;
        if (rot !== 2'd0 || piece_x !== 5'sd3) begin
            n_fail++;
            $display("FAIL rot_blocked_col5: got rot=%0d x=%0d, want 0 3", rot, piece_x);
        end
        board[3][5] = 1'b0;
        request(2, n);
        n_checks++;
        if (rot !== 2'd1) begin n_fail++; $display("FAIL rot_to_1: got %0d, want 1", rot); end
        request(2, n);
        request(2, n);
        n_checks++;
        if (rot !== 2'd3) begin n_fail++; $display("FAIL rot_to_3: got %0d, want 3", rot); end
        request(2, n);
        n_checks++;
        if (rot !== 2'd0) begin n_fail++; $display("FAIL rot_wrap: got %0d, want 0", rot); end
    endtask

    task automatic test_gravity_lock();
        int n;
        int k;
        wr_t e;
        wr_t o;
        do_reset(3'd0, n);
        for (int i = 0; i < 18; i++) request(3, n);
        n_checks++;
        if (piece_y !== 6'sd18) begin n_fail++; $display("FAIL fall_to_18: got y=%0d, want 18", piece_y); end
        obs_rd = obs_q.size();
        for (int i = 0; i < 4; i++) exp_q.push_back('{x: 4'(3 + i), y: 5'd19, d: 1'b1});
        tick_gravity = 1'b1;
        step();
        tick_gravity = 1'b0;
        k = 0;
        while (lock_done !== 1'b1 && k < 40) begin step(); k++; end
        n_checks++;
        if (lock_done !== 1'b1) begin n_fail++; $display("FAIL lock_done_seen: got %b, want 1", lock_done); end
        n_checks++;
        if (cyc !== last_we_cyc + 1) begin
            n_fail++;
            $display("FAIL lock_done_timing: got cycle %0d, want %0d", cyc, last_we_cyc + 1);
        end
        step();
        n_checks++;
        if (lock_done !== 1'b0) begin n_fail++; $display("FAIL lock_done_pulse: got %b, want 0", lock_done); end
        for (int i = 0; i < 5; i++) step();
        n_checks++;
        if (busy !== 1'b1 || piece_y !== 6'sd18) begin
            n_fail++;
            $display("FAIL wait_clr_hold: got busy=%b y=%0d, want 1 18", busy, piece_y);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_rd >= obs_q.size()) begin
                n_fail++;
                $display("FAIL lock_write_missing: got none, want x=%0d y=%0d", e.x, e.y);
            end else begin
                o = obs_q[obs_rd];
                obs_rd++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL lock_write: got x=%0d y=%0d d=%b, want x=%0d y=%0d d=%b", o.x, o.y, o.d, e.x, e.y, e.d);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != obs_rd) begin
            n_fail++;
            $display("FAIL lock_write_extra: got %0d writes, want %0d", obs_q.size(), obs_rd);
        end
        clear_done = 1'b1;
        step();
        clear_done = 1'b0;
        wait_fall(n);
        n_checks++;
        if (n !== 6 || piece_y !== 6'sd0 || piece_x !== 5'sd3) begin
            n_fail++;
            $display("FAIL respawn: got cycles=%0d x=%0d y=%0d, want 6 3 0", n, piece_x, piece_y);
        end
    endtask

    task automatic test_game_over();
        int n0;
        n0 = obs_q.size();
        board[1][4] = 1'b1;
        resetn = 1'b0;
        step();
        step();
        spawn_shape = 3'd2;
        resetn = 1'b1;
        for (int i = 0; i < 20; i++) step();
        n_checks++;
        if (game_over !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL game_over_set: got game_over=%b busy=%b, want 1 1", game_over, busy);
        end
        left_final = 1'b1; tick_gravity = 1'b1; clear_done = 1'b1;
        step();
        left_final = 1'b0; tick_gravity = 1'b0; clear_done = 1'b0;
        for (int i = 0; i < 10; i++) step();
        n_checks++;
        if (game_over !== 1'b1) begin n_fail++; $display("FAIL game_over_absorb: got %b, want 1", game_over); end
        n_checks++;
        if (obs_q.size() != n0) begin
            n_fail++;
            $display("FAIL game_over_writes: got %0d writes, want 0", obs_q.size() - n0);
        end
        resetn = 1'b0;
        step();
        n_checks++;
        if (game_over !== 1'b0) begin n_fail++; $display("FAIL game_over_reset: got %b, want 0", game_over); end
        board[1][4] = 1'b0;
    endtask

    task automatic test_reset_mid_lock();
        int n;
        int k;
        wr_t e;
        wr_t o;
        do_reset(3'd0, n);
        for (int i = 0; i < 18; i++) request(3, n);
        obs_rd = obs_q.size();
        for (int i = 0; i < 2; i++) exp_q.push_back('{x: 4'(3 + i), y: 5'd19, d: 1'b1});
        tick_gravity = 1'b1;
        step();
        tick_gravity = 1'b0;
        k = 0;
        while (board_we !== 1'b1 && k < 40) begin step(); k++; end
        step();
        n_checks++;
        if (board_we !== 1'b1) begin n_fail++; $display("FAIL lock_write2_present: got we=%b, want 1", board_we); end
        resetn = 1'b0;
        step();
        n_checks++;
        if (board_we !== 1'b0) begin n_fail++; $display("FAIL reset_abort_we: got %b, want 0", board_we); end
        for (int i = 0; i < 6; i++) step();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_rd >= obs_q.size()) begin
                n_fail++;
                $display("FAIL abort_write_missing: got none, want x=%0d y=%0d", e.x, e.y);
            end else begin
                o = obs_q[obs_rd];
                obs_rd++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL abort_write: got x=%0d y=%0d, want x=%0d y=%0d", o.x, o.y, e.x, e.y);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != obs_rd) begin
            n_fail++;
            $display("FAIL abort_write_extra: got %0d writes, want %0d", obs_q.size(), obs_rd);
        end
    endtask

    initial begin
        clear_board();
        test_reset();
        test_spawn();
        test_move();
        test_priority();
        test_rotate();
        test_gravity_lock();
        test_game_over();
        test_reset_mid_lock();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/piece_engine.md
PIECE_ENGINE -- requirements
Module: piece_engine

Interface
REQ-001 Parameter COLS, 10, board width in cells.
REQ-002 Parameter ROWS, 20, board height in cells.
REQ-003 Parameter XW, 4, unsigned column address width (2^XW >= COLS).
REQ-004 Parameter YW, 5, unsigned row address width (2^YW >= ROWS).
REQ-005 Parameter SPAWN_X, 3, spawn column of the 4x4 piece box origin.
REQ-006 CLOCK_50  in  1  clock; reset resetn, synchronous, active-low; clock CLOCK_50.
REQ-007 resetn  in  1  synchronous active-low reset.
REQ-008 left_final, right_final, rot_final  in  1 each  debounced one-cycle move requests.
REQ-009 tick_gravity  in  1  one-cycle gravity request.
REQ-010 spawn_shape  in  3  shape for next spawn (0 I, 1 O, 2 T, 3 S, 4 Z, 5 J, 6 L; 7 treated as 0).
REQ-011 clear_done  in  1  one-cycle pulse from the line-clear block ending post-lock clearing.
REQ-012 board_rx/board_ry  out  XW/YW  board read address; board_rdata  in  1  occupancy, valid one cycle after address.
REQ-013 board_we  out  1; board_wx/board_wy  out  XW/YW; board_wdata  out  1  board write port.
REQ-014 piece_x  out  XW+1 signed; piece_y  out  YW+1 signed; rot  out  2; shape_id  out  3  active piece state.
REQ-015 lock_done  out  1  one-cycle pulse after the 4th lock write; game_over  out  1  level; busy  out  1  high in every state except FALL.

Function
REQ-016 States: IDLE, SPAWN, FALL, CHECK, LOCK, WAIT_CLR, OVER; IDLE -> SPAWN unconditionally.
REQ-017 Shape offsets in a 4x4 box, rot 0 (dx,dy): I (0,1)(1,1)(2,1)(3,1); O (1,0)(2,0)(1,1)(2,1); T (1,0)(0,1)(1,1)(2,1); S (1,0)(2,0)(0,1)(1,1); Z (0,0)(1,0)(1,1)(2,1); J (0,0)(0,1)(1,1)(2,1); L (2,0)(0,1)(1,1)(2,1).
REQ-018 Rotation r+1 maps each offset (dx,dy) -> (3-dy,dx), clockwise; rot wraps 3 -> 0; O uses rot 0 offsets for all rot values.
REQ-019 SPAWN: latch shape_id from spawn_shape, rot=0, piece_x=SPAWN_X, piece_y=0, then run CHECK with zero delta.
REQ-020 FALL priority: left (dX=-1) > right (dX=+1) > rot (dRot=+1) > gravity (dY=+1); one request per cycle accepted, others in that cycle dropped.
REQ-021 CHECK: cells i=0..3 issue address on consecutive cycles, last rdata sampled on the 5th cycle; CHECK lasts exactly 5 cycles.
REQ-022 Target tx=piece_x+dX+dx, ty=piece_y+dY+dy in signed XW+2/YW+2 bits; tx<0, tx>=COLS, ty<0 or ty>=ROWS collides without relying on rdata.
REQ-023 No collision: commit piece_x+=dX, piece_y+=dY, rot=(rot+dRot) mod 4 on the cycle leaving CHECK, return to FALL.
REQ-024 Collision: left/right/rot discarded, return to FALL; gravity -> LOCK; spawn check -> OVER.
REQ-025 Requests arriving outside FALL are ignored (not queued).
REQ-026 LOCK: 4 consecutive cycles board_we=1, board_wdata=1, board_wx/wy = cell i of current piece; lock_done pulses the cycle after the 4th write; then WAIT_CLR.
REQ-027 WAIT_CLR -> SPAWN on clear_done; clear_done in any other state ignored.
REQ-028 OVER: game_over=1, board_we=0, absorbing until reset.
REQ-029 board_we high only in LOCK.

Reset
REQ-030 On resetn=0 at a clock edge: state IDLE, piece_x=0, piece_y=0, rot=0, shape_id=0, board_we=0, board_wdata=0, all addresses 0, lock_done=0, game_over=0; mid-CHECK or mid-LOCK aborts with no further writes.

Verification
REQ-031 Empty board, spawn_shape=2 -> piece_x=3, piece_y=0, rot=0, FALL reached 7 cycles after reset release; game_over=0.
REQ-032 T at piece_x=0 rot 0, left_final -> no move, FALL after 5 cycles; right_final -> piece_x=1.
REQ-033 I rot 0 at piece_y=18, tick_gravity -> collide (ty=20), 4 writes to (3..6,19), lock_done one cycle after last write, busy until clear_done.
REQ-034 I rot 0 at piece_x=3, rot_final -> rot=1, occupied column 5; rot_final at rot=3 -> rot=0.
REQ-035 Board cell (4,1) preset occupied, spawn T -> game_over=1, no board_we ever, stays OVER until resetn=0.
REQ-036 left_final and tick_gravity same cycle -> only left performed; tick_gravity during CHECK ignored; resetn low during LOCK write 2 -> no write 3.
